shrimp_alu_issue: RTL and testbench



---
 rtl/shrimp_alu_issue.sv | 187 ++++++++++++++++++
 tb/tb_shrimp_alu_issue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shrimp_alu_issue.sv
// shrimp_alu_issue: issue/sequencing front end for the combinational shrimp ALU.
// It accepts a request (function code + two operands), expands it into one or
// two ALU micro-ops, and returns the post-processed result over valid/ready.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     request handshake; in_func/in_a/in_b are the request
//   alu_op/alu_a/alu_b    micro-op driven to the ALU
//   alu_result            combinational ALU result for the current micro-op
//   out_valid/out_ready   result handshake; out_result/out_err are the result
module shrimp_alu_issue #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_func,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err
);

  typedef enum logic [3:0] {
    OP_XOR  = 4'd0,
    OP_AND  = 4'd1,
    OP_OR   = 4'd2,
    OP_ADDU = 4'd3,
    OP_ADDS = 4'd4,
    OP_NEG  = 4'd5,
    OP_CMP  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9
  } alu_opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Macro-op function codes (codes 0..9 map straight onto ALU opcodes).
  localparam logic [3:0] F_SUB = 4'd10;
  localparam logic [3:0] F_SLT = 4'd11;
  localparam logic [3:0] F_SEQ = 4'd12;
  localparam logic [3:0] F_NOT = 4'd13;

  state_e           r_state;
  logic [3:0]       r_func;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_tmp;
  logic [WIDTH-1:0] r_result;
  logic             r_err;

  alu_opcode_e      w_op;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic [WIDTH-1:0] w_post;
  logic             w_illegal;

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign out_result = r_result;
  assign out_err    = r_err;
  assign alu_op     = w_op;
  assign alu_a      = w_alu_a;
  assign alu_b      = w_alu_b;

  // Codes 14 and 15 are the only illegal ones.
  assign w_illegal = (in_func[3:1] == 3'b111);

  // Micro-op selection. Outside EXEC1/EXEC2 the ALU sees a harmless XOR of zeros.
  always_comb begin
    w_op    = OP_XOR;
    w_alu_a = '0;
    w_alu_b = '0;
    case (r_state)
      EXEC1: begin
        case (r_func)
          F_SUB: begin
            // First half of A-B: negate B.
            w_op    = OP_NEG;
            w_alu_a = r_b;
            w_alu_b = '0;
          end
          F_SLT, F_SEQ: begin
            w_op    = OP_CMP;
            w_alu_a = r_a;
            w_alu_b = r_b;
          end
          F_NOT: begin
            w_op    = OP_XOR;
            w_alu_a = r_a;
            w_alu_b = '1;
          end
          default: begin
            w_op    = alu_opcode_e'(r_func);
            w_alu_a = r_a;
            w_alu_b = r_b;
          end
        endcase
      end
      EXEC2: begin
        // Second half of A-B: A + (-B).
        w_op    = OP_ADDS;
        w_alu_a = r_a;
        w_alu_b = r_tmp;
      end
      default: begin
        w_op    = OP_XOR;
        w_alu_a = '0;
        w_alu_b = '0;
      end
    endcase
  end

  // Result post-processing for single-step ops: comparisons reduce to one flag bit.
  always_comb begin
    case (r_func)
      F_SLT:   w_post = {{(WIDTH-1){1'b0}}, alu_result[1]};
      F_SEQ:   w_post = {{(WIDTH-1){1'b0}}, alu_result[2]};
      default: w_post = alu_result;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_func   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_tmp    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_func <= in_func;
            r_a    <= in_a;
            r_b    <= in_b;
            if (w_illegal) begin
              r_result <= '0;
              r_err    <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= EXEC1;
            end
          end
        end
        EXEC1: begin
          r_tmp <= alu_result;
          if (r_func == F_SUB) begin
            r_state <= EXEC2;
          end else begin
            r_result <= w_post;
            r_state  <= DONE;
          end
        end
        EXEC2: begin
          r_tmp    <= alu_result;
          r_result <= alu_result;
          r_state  <= DONE;
        end
        DONE: begin
          // No bypass: the next request can only be taken once back in IDLE.
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shrimp_alu_issue.sv
module tb_shrimp_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int acc_cyc[$];

  // ALU observations per negedge after accept (index 1 = first cycle after accept)
  logic [3:0]  cap_op [0:7];
  logic [31:0] cap_a  [0:7];
  logic [31:0] cap_b  [0:7];

  shrimp_alu_issue #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_func    (in_func),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (in_valid && in_ready) begin
      n_acc++;
      acc_cyc.push_back(cyc);
    end
  end

  // Behavioural ALU: CMP returns {eq, signed lt, signed gt}.
  always_comb begin
    case (alu_op)
      4'd0:    alu_result = alu_a ^ alu_b;
      4'd1:    alu_result = alu_a & alu_b;
      4'd2:    alu_result = alu_a | alu_b;
      4'd3:    alu_result = alu_a + alu_b;
      4'd4:    alu_result = alu_a + alu_b;
      4'd5:    alu_result = 32'd0 - alu_a;
      4'd6:    alu_result = {29'd0, alu_a == alu_b, $signed(alu_a) < $signed(alu_b),
                             $signed(alu_a) > $signed(alu_b)};
      4'd7:    alu_result = alu_a << alu_b[4:0];
      4'd8:    alu_result = alu_a >> alu_b[4:0];
      4'd9:    alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = 32'd0;
    endcase
  end

  // Expected architectural result of a whole request.
  function automatic logic [31:0] ref_result(input logic [3:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    case (f)
      4'd0:  return a ^ b;
      4'd1:  return a & b;
      4'd2:  return a | b;
      4'd3:  return a + b;
      4'd4:  return a + b;
      4'd5:  return 32'd0 - a;
      4'd6:  return {29'd0, a == b, $signed(a) < $signed(b), $signed(a) > $signed(b)};
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return 32'($signed(a) >>> b[4:0]);
      4'd10: return a - b;
      4'd11: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: return (a == b) ? 32'd1 : 32'd0;
      4'd13: return ~a;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic do_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    int lat;
    int acc0;
    logic [31:0] exp_r;
    logic        exp_e;
    int          exp_lat;
    exp_r   = ref_result(f, a, b);
    exp_e   = (f >= 4'd14);
    exp_lat = exp_e ? 1 : ((f == 4'd10) ? 3 : 2);
    for (int k = 0; k < 8; k++) begin
      cap_op[k] = '0; cap_a[k] = '0; cap_b[k] = '0;
    end
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    acc0 = n_acc;
    in_valid  = 1'b1;
    in_func   = f;
    in_a      = a;
    in_b      = b;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_func  = 4'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      cap_op[lat] = alu_op;
      cap_a[lat]  = alu_a;
      cap_b[lat]  = alu_b;
      if (!out_valid) chk("in_ready_busy", 32'(in_ready), 32'd0);
    end while (!out_valid && lat < 6);
    $display("op f=%0d a=%08h b=%08h -> res=%08h err=%0d lat=%0d (exp %08h/%0d/%0d)",
             f, a, b, out_result, out_err, lat, exp_r, exp_e, exp_lat);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", out_result, exp_r);
    chk("err", 32'(out_err), 32'(exp_e));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    chk("alu_op_done", 32'(alu_op), 32'd0);
    // Backpressure: outputs must hold while in_valid pulses are ignored.
    for (int j = 0; j < hold; j++) begin
      in_valid = (j % 2 == 0);
      in_func  = 4'($urandom);
      in_a     = $urandom;
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", out_result, exp_r);
      chk("hold_err", 32'(out_err), 32'(exp_e));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("accepts", 32'(n_acc - acc0), 32'd1);
  endtask

  initial begin
    int lat;
    int base;
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_func   = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);

    // ADDU wrap
    do_op(4'd3, 32'hFFFF_FFFF, 32'd1, 0);
    chk("addu_e1_op", 32'(cap_op[1]), 32'd3);
    chk("addu_e1_a", cap_a[1], 32'hFFFF_FFFF);

    // SUB micro-op sequence
    do_op(4'd10, 32'd5, 32'd7, 1);
    chk("sub_e1_op", 32'(cap_op[1]), 32'd5);
    chk("sub_e1_a", cap_a[1], 32'd7);
    chk("sub_e2_op", 32'(cap_op[2]), 32'd4);
    chk("sub_e2_a", cap_a[2], 32'd5);
    chk("sub_e2_b", cap_b[2], 32'hFFFF_FFF9);

    // Comparisons
    do_op(4'd11, 32'd2, 32'd9, 0);
    chk("slt_e1_op", 32'(cap_op[1]), 32'd6);
    do_op(4'd12, 32'd4, 32'd4, 0);
    do_op(4'd12, 32'd4, 32'd5, 0);
    do_op(4'd11, 32'hFFFF_FFFE, 32'd3, 0);

    // Illegal with 5 cycles of backpressure
    do_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 5);
    do_op(4'd14, 32'd1, 32'd2, 0);

    // NOT operand drive
    do_op(4'd13, 32'h0F0F_0F0F, 32'd0, 0);
    chk("not_e1_b", cap_b[1], 32'hFFFF_FFFF);

    // Back-to-back NOT with in_valid held high
    @(negedge clk);
    base      = acc_cyc.size();
    in_valid  = 1'b1;
    in_func   = 4'd13;
    in_a      = 32'h0F0F_0F0F;
    in_b      = $urandom;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!out_valid && lat < 8);
      $display("b2b NOT #%0d res=%08h err=%0d", k, out_result, out_err);
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_result", out_result, 32'hF0F0_F0F0);
      chk("b2b_err", 32'(out_err), 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_accepts", 32'(acc_cyc.size() - base), 32'd3);
    if (acc_cyc.size() >= base + 3) begin
      chk("b2b_interval1", 32'(acc_cyc[base+1] - acc_cyc[base]), 32'd3);
      chk("b2b_interval2", 32'(acc_cyc[base+2] - acc_cyc[base+1]), 32'd3);
    end

    // Asynchronous reset in EXEC2
    @(negedge clk);
    in_valid  = 1'b1;
    in_func   = 4'd10;
    in_a      = 32'd5;
    in_b      = 32'd7;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_alu_op", 32'(alu_op), 32'd4);
    rst_n = 1'b0;
    #1;
    $display("async reset in EXEC2: in_ready=%0d out_valid=%0d", in_ready, out_valid);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_alu_op", 32'(alu_op), 32'd0);
    chk("arst_out_result", out_result, 32'd0);
    chk("arst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("arst_after_valid", 32'(out_valid), 32'd0);
    chk("arst_after_ready", 32'(in_ready), 32'd1);

    // Randomized requests
    for (int i = 0; i < 40; i++) begin
      f = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      do_op(f, a, b, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
